// File: rtl/mult_pkg.sv
// Shared helpers for the multiplier family: signedness strings, clog2,
// round-half-up constant and a generic saturation function.
package mult_pkg;

  localparam string SIGNED_STR   = "SIGNED";
  localparam string UNSIGNED_STR = "UNSIGNED";

  // Widest value the helpers below operate on; callers extend into this width.
  localparam int MAX_W = 128;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] round_const(input int shift);
    logic [MAX_W-1:0] c;
    c = '0;
    if (shift > 0) c = MAX_W'(1) << (shift - 1);
    return c;
  endfunction

  // Returns {sat, value}; value must already be sign/zero-extended to MAX_W.
  // Only the low out_w bits of the returned value are meaningful.
  function automatic logic [MAX_W:0] saturate(input logic [MAX_W-1:0] value,
                                               input int out_w,
                                               input bit is_signed);
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    logic [MAX_W:0]   res;
    res = {1'b0, value};
    if (is_signed) begin
      hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
      lo = ~hi;
      if ($signed(value) > $signed(hi)) res = {1'b1, hi};
      else if ($signed(value) < $signed(lo)) res = {1'b1, lo};
    end else begin
      hi = (MAX_W'(1) << out_w) - MAX_W'(1);
      if (value > hi) res = {1'b1, hi};
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_acc_ofifo.sv
// Two-entry first-word-fall-through result FIFO; a push is accepted when
// full only if a pop happens in the same cycle.
module mult_acc_ofifo #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);

  logic [DATA_W-1:0] mem_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              do_pop;
  logic              do_push;

  assign full    = count_reg[1];
  assign empty   = (count_reg == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mult_prod_accum.sv
// Frame accumulator behind the pipelined multiplier: sums ACC_LEN products, then
// rounds, shifts and saturates into a 2-entry FIFO. MULT_ACC_STATS_EN adds sat_cnt.
module mult_prod_accum
  import mult_pkg::*;
#(
  parameter int    PROD_WIDTH = 62,
  parameter string SIGNED     = "SIGNED",
  parameter int    ACC_LEN    = 16,
  parameter int    SHIFT      = 20,
  parameter int    OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  ovf_err,
  input  logic                  err_clr,
  output logic [15:0]           sat_cnt
);

  localparam bit   IS_SIGNED = (SIGNED == SIGNED_STR);
  localparam int   ACC_W     = PROD_WIDTH + clog2(ACC_LEN);
  localparam int   RW        = ACC_W + 1;
  localparam int   CNT_W     = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic [RW-1:0]    RND      = RW'(round_const(SHIFT));

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] s1_sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             s1_v_reg;

  if (IS_SIGNED && (ACC_W > PROD_WIDTH)) begin : g_sext
    assign prod_ext = {{(ACC_W-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
  end else begin : g_zext
    assign prod_ext = ACC_W'(in_prod);
  end

  // clr has priority over a coincident sample, which is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      s1_sum_reg <= '0;
      s1_v_reg   <= 1'b0;
    end else if (clr) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      s1_v_reg <= 1'b0;
    end else begin
      s1_v_reg <= 1'b0;
      if (in_valid) begin
        if (cnt_reg == CNT_LAST) begin
          s1_sum_reg <= acc_reg + prod_ext;
          s1_v_reg   <= 1'b1;
          acc_reg    <= '0;
          cnt_reg    <= '0;
        end else begin
          acc_reg <= acc_reg + prod_ext;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  logic [RW-1:0]        sum_x;
  logic [RW-1:0]        sum_rnd;
  logic signed [RW-1:0] sum_rnd_s;
  logic [RW-1:0]        r_shift;
  logic [MAX_W-1:0]     r_ext;
  logic [MAX_W:0]       sat_res;
  logic                 sat_res_unused;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  always_comb begin
    sum_x = {1'b0, s1_sum_reg};
    if (IS_SIGNED) sum_x = {s1_sum_reg[ACC_W-1], s1_sum_reg};
    sum_rnd   = sum_x + RND;
    sum_rnd_s = sum_rnd;
    r_shift   = sum_rnd >> SHIFT;
    if (IS_SIGNED) r_shift = sum_rnd_s >>> SHIFT;
    r_ext = {{(MAX_W-RW){1'b0}}, r_shift};
    if (IS_SIGNED) r_ext = {{(MAX_W-RW){r_shift[RW-1]}}, r_shift};
    sat_res = saturate(r_ext, OUT_WIDTH, IS_SIGNED);
  end

  assign sat_res_unused = ^sat_res[MAX_W-1:OUT_WIDTH];

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 push_ok;
  logic                 drop;
  logic [OUT_WIDTH:0]   fifo_dout;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign push_ok   = s1_v_reg && (!fifo_full || fifo_pop);
  assign drop      = s1_v_reg && fifo_full && !fifo_pop;
  assign out_sat   = fifo_dout[OUT_WIDTH];
  assign out_data  = fifo_dout[OUT_WIDTH-1:0];

  mult_acc_ofifo #(
    .DATA_W(OUT_WIDTH + 1)
  ) u_ofifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (s1_v_reg),
    .din  ({sat_res[MAX_W], sat_res[OUT_WIDTH-1:0]}),
    .full (fifo_full),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (drop) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

`ifdef MULT_ACC_STATS_EN
  logic [15:0] sat_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_reg <= 16'd0;
    end else if (push_ok && sat_res[MAX_W] && (sat_cnt_reg != 16'hFFFF)) begin
      sat_cnt_reg <= sat_cnt_reg + 16'd1;
    end
  end
  assign sat_cnt = sat_cnt_reg;
`else
  logic push_ok_unused;
  assign push_ok_unused = push_ok;
  assign sat_cnt = 16'd0;
`endif

endmodule
